// File: rtl/dec_neuron_mac_if.sv
// Activation-in / result-out handshake bundle for one decoder neuron MAC.
// The master side is the producer/consumer around the engine; the slave side is the engine.
interface dec_neuron_mac_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dec_neuron_mac.sv
// Sequential single-neuron dot product: one activation x weight per cycle into a wide
// accumulator, then bias add, round-half-up, saturate, optional ReLU, one result out.
module dec_neuron_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 10,
  parameter int N_TAPS     = 16,
  parameter int RELU_EN    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_TAPS*DATA_WIDTH-1:0] w_flat,
  input  logic [DATA_WIDTH-1:0]        bias,
  input  logic                         clear,
  dec_neuron_mac_if.slave              io,
  output logic                         busy
);
  localparam int IDX_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int ACC_W  = 2*DATA_WIDTH + $clog2(N_TAPS) + 1;
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_TAPS-1);

  typedef enum logic [1:0] {RUN, RND, OUT} state_t;

  state_t                              state;
  logic [IDX_W-1:0]                    idx;
  logic signed [ACC_W-1:0]             acc;
  logic                                out_valid_q;
  logic [DATA_WIDTH-1:0]               out_data_q;

  logic [N_TAPS-1:0][DATA_WIDTH-1:0]   w;
  logic signed [PROD_W-1:0]            prod;
  logic signed [ACC_W-1:0]             prod_ext;
  logic signed [ACC_W-1:0]             bias_ext;
  logic signed [ACC_W-1:0]             half;
  logic signed [ACC_W-1:0]             rnd_sum;
  logic signed [ACC_W-1:0]             rnd_shr;
  logic signed [ACC_W-1:0]             sat_hi;
  logic signed [ACC_W-1:0]             sat_lo;
  logic [DATA_WIDTH-1:0]               res;

  assign w = w_flat;

  // Full-precision signed product of the current tap, widened into the accumulator.
  assign prod     = $signed(io.in_data) * $signed(w[idx]);
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  assign bias_ext = {{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
  assign half     = ACC_W'(1) <<< (FRAC_BITS-1);
  assign sat_hi   = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  assign sat_lo   = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Adding half an LSB then arithmetic-shifting rounds ties toward +inf.
  always_comb begin
    rnd_sum = acc + (bias_ext <<< FRAC_BITS) + half;
    rnd_shr = rnd_sum >>> FRAC_BITS;
    if (rnd_shr > sat_hi)      res = sat_hi[DATA_WIDTH-1:0];
    else if (rnd_shr < sat_lo) res = sat_lo[DATA_WIDTH-1:0];
    else                       res = rnd_shr[DATA_WIDTH-1:0];
    if ((RELU_EN != 0) && res[DATA_WIDTH-1]) res = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      idx         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clear) begin
      state       <= RUN;
      idx         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        RUN: if (io.in_valid) begin
          acc <= acc + prod_ext;
          if (idx == LAST) begin
            idx   <= '0;
            state <= RND;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RND: begin
          out_data_q  <= res;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: if (io.out_ready) begin
          out_valid_q <= 1'b0;
          acc         <= '0;
          state       <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // clear blocks acceptance in the same cycle so an aborted vector never absorbs a tap.
  assign io.in_ready  = (state == RUN) && !clear;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign busy         = (state != RUN) || (idx != '0);
endmodule

// File: tb/tb_dec_neuron_mac.sv
// Directed plus randomized bench for dec_neuron_mac; one instance without and one with ReLU
// share all stimulus and are compared against an integer-arithmetic reference.
module tb_dec_neuron_mac;
  localparam int DW = 16;
  localparam int NT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic [NT*DW-1:0] w_flat = '0;
  logic [DW-1:0] bias = '0;
  logic busy0, busy1;

  logic [DW-1:0] wv [NT];
  logic [DW-1:0] av [NT];

  int checks = 0;
  int errors = 0;

  dec_neuron_mac_if #(.DATA_WIDTH(DW)) io0 ();
  dec_neuron_mac_if #(.DATA_WIDTH(DW)) io1 ();

  assign io0.in_valid = in_valid;  assign io1.in_valid = in_valid;
  assign io0.in_data  = in_data;   assign io1.in_data  = in_data;
  assign io0.out_ready = out_ready; assign io1.out_ready = out_ready;

  dec_neuron_mac #(.DATA_WIDTH(DW), .FRAC_BITS(10), .N_TAPS(NT), .RELU_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .w_flat(w_flat), .bias(bias), .clear(clear), .io(io0), .busy(busy0));
  dec_neuron_mac #(.DATA_WIDTH(DW), .FRAC_BITS(10), .N_TAPS(NT), .RELU_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .w_flat(w_flat), .bias(bias), .clear(clear), .io(io1), .busy(busy1));

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact dot product, bias in Q-format, floor((s + 0.5 LSB)), clamp, optional ReLU.
  function automatic logic [DW-1:0] model(input bit relu);
    longint s = 0;
    for (int k = 0; k < NT; k++)
      s += longint'($signed(wv[k])) * longint'($signed(av[k]));
    s += longint'($signed(bias)) * 1024;
    s = (s + 512) >>> 10;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s[DW-1:0];
  endfunction

  task automatic load_w();
    for (int k = 0; k < NT; k++) w_flat[k*DW +: DW] = wv[k];
  endtask

  task automatic set_all(input logic [DW-1:0] wval, input logic [DW-1:0] aval, input logic [DW-1:0] b);
    for (int k = 0; k < NT; k++) begin wv[k] = wval; av[k] = aval; end
    bias = b;
    load_w();
  endtask

  // Offers av[0..n-1] with random idle gaps; returns with the last accept edge just passed.
  task automatic feed(input int n, input int gap_max, input string tag);
    int k = 0;
    int cyc = 0;
    bit acc_now;
    while (k < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if ($urandom_range(0, gap_max) == 0) begin
        in_valid = 1'b1; in_data = av[k];
      end else begin
        in_valid = 1'b0; in_data = DW'($urandom);
      end
      #1 acc_now = in_valid && io0.in_ready;
      @(posedge clk);
      if (acc_now) k++;
    end
    if (k < n) chk(k, n, {tag, "_timeout"});
  endtask

  // mode 0: normal drain with bp cycles of backpressure; 1: clear while in OUT; 2: reset while in OUT.
  task automatic vec(input int gap_max, input int bp, input int mode, input string tag);
    logic [DW-1:0] e0, e1;
    e0 = model(1'b0);
    e1 = model(1'b1);
    out_ready = (bp == 0 && mode == 0);
    feed(NT, gap_max, tag);
    @(negedge clk);
    in_valid = 1'b0;
    chk(io0.out_valid, 0, {tag, "_rnd_ovalid"});
    chk(io0.in_ready, 0, {tag, "_rnd_iready"});
    chk(busy0, 1, {tag, "_rnd_busy"});
    @(negedge clk);
    chk(io0.out_valid, 1, {tag, "_ovalid"});
    chk(io0.out_data, e0, {tag, "_data"});
    chk(io1.out_data, e1, {tag, "_data_relu"});
    chk(io0.in_ready, 0, {tag, "_out_iready"});
    if (mode == 1) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk(io0.out_valid, 0, {tag, "_clr_ovalid"});
      chk(busy0, 0, {tag, "_clr_busy"});
      return;
    end
    if (mode == 2) begin
      rst_n = 1'b0;
      #1;
      chk(io0.out_valid, 0, {tag, "_rst_ovalid"});
      chk(io0.in_ready, 1, {tag, "_rst_iready"});
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({io0.out_valid, io0.in_ready, io0.out_data}, {1'b1, 1'b0, e0}, {tag, "_bp_hold"});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk(io0.out_valid, 0, {tag, "_done_ovalid"});
    chk(io0.in_ready, 1, {tag, "_done_iready"});
    chk(busy0, 0, {tag, "_done_busy"});
  endtask

  task automatic rand_vec(input bit full);
    for (int k = 0; k < NT; k++) begin
      wv[k] = full ? DW'($urandom) : DW'($urandom_range(0, 2047) - 1024);
      av[k] = full ? DW'($urandom) : DW'($urandom_range(0, 2047) - 1024);
    end
    bias = DW'($urandom_range(0, 8191) - 4096);
    load_w();
  endtask

  initial begin
    // Reset state
    #2;
    chk(io0.out_valid, 0, "rst_ovalid");
    chk(io0.out_data, 0, "rst_odata");
    chk(busy0, 0, "rst_busy");
    chk(io0.in_ready, 1, "rst_iready");
    @(negedge clk); rst_n = 1'b1;

    // Unity weights and activations: 16 * 1.0 = 0x4000, back-to-back valid
    set_all(16'h0400, 16'h0400, 16'h0000);
    vec(0, 0, 0, "unity");

    // Single tap, negative result; ReLU instance clamps to 0
    set_all(16'h0000, 16'h0000, 16'hFFFD);
    wv[10] = 16'hF8FE; av[10] = 16'h0400; load_w();
    vec(2, 0, 0, "tap10");
    chk(model(1'b0), 16'hF8FB, "tap10_ref");

    // Saturation at both ends
    set_all(16'h7FFF, 16'h7FFF, 16'h0000);
    vec(0, 0, 0, "sat_hi");
    set_all(16'h8000, 16'h7FFF, 16'h0000);
    vec(1, 0, 0, "sat_lo");

    // Rounding: exact half rounds up, just below half rounds down, negative half to 0
    set_all(16'h0000, 16'h0000, 16'h0000);
    wv[0] = 16'h0001; av[0] = 16'h0200; load_w();
    vec(0, 0, 0, "rnd_half");
    av[0] = 16'h01FF;
    vec(0, 0, 0, "rnd_below");
    wv[0] = 16'hFFFF; av[0] = 16'h0200; load_w();
    vec(0, 0, 0, "rnd_neg_half");

    // Backpressure, then an independent back-to-back vector
    rand_vec(1'b0);
    vec(0, 5, 0, "bp5");
    rand_vec(1'b0);
    vec(0, 0, 0, "b2b");

    // clear after 7 accepts, with a tap offered alongside clear
    set_all(16'h0400, 16'h0400, 16'h0000);
    out_ready = 1'b1;
    feed(7, 0, "clr7");
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h7FFF;
    #1 chk(io0.in_ready, 0, "clr7_iready");
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk(busy0, 0, "clr7_busy");
    vec(0, 0, 0, "after_clr7");

    // clear while a result is pending, then a fresh vector
    rand_vec(1'b0);
    vec(0, 0, 1, "clr_out");
    vec(0, 0, 0, "after_clr_out");

    // Reset mid-vector takes effect immediately
    out_ready = 1'b1;
    feed(5, 0, "rstmid");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk(io0.out_valid, 0, "rstmid_ovalid");
    chk(io0.in_ready, 1, "rstmid_iready");
    chk(busy0, 0, "rstmid_busy");
    @(negedge clk); rst_n = 1'b1;
    vec(0, 0, 0, "after_rstmid");

    // Reset while in OUT
    rand_vec(1'b0);
    vec(0, 0, 2, "rst_out");
    vec(0, 0, 0, "after_rst_out");

    // Randomized vectors with gaps and backpressure
    for (int t = 0; t < 12; t++) begin
      rand_vec(t[0]);
      vec(t % 3, t % 4, 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
